// File: rtl/seg_pkg.sv
// seg_pkg: shared slot states, default scanner constants and the digit one-hot helper
package seg_pkg;
  localparam int SEG_DIGITS       = 4;
  localparam int SEG_REFRESH_DIV  = 50000;
  localparam int SEG_BLANK_CYCLES = 16;
  typedef enum logic {BLANK, SHOW} slot_state_t;
  function automatic logic [7:0] onehot(input logic [2:0] idx, input int digits);
    return (int'(idx) < digits) ? (8'd1 << idx) : 8'd0;
  endfunction
endpackage

// File: rtl/seg_lz_mask.sv
// seg_lz_mask: leading-zero suppression mask (ports: value_i nibbles, lz_i enable, mask_o per-digit suppress)
module seg_lz_mask #(
  parameter int DIGITS = 4
) (
  input  logic [4*DIGITS-1:0] value_i,
  input  logic                lz_i,
  output logic [DIGITS-1:0]   mask_o
);
  for (genvar g = 0; g < DIGITS; g++) begin : g_mask
    if (g == 0) begin : g_lsd
      assign mask_o[g] = 1'b0;
    end else begin : g_hi
      assign mask_o[g] = lz_i && ~|value_i[4*DIGITS-1:4*g];
    end
  end
endmodule

// File: rtl/seg_scanner.sv
// seg_scanner: blanked, frame-synchronous multi-digit scan driver (ports: clk/rst, load_i+value_i/hex_mode_i/lz_en_i shadow load, num_o/is_hex_o to decoder, digit_en_o commons, frame_done_o, pending_o)
module seg_scanner
  import seg_pkg::*;
#(
  parameter int DIGITS       = SEG_DIGITS,
  parameter int REFRESH_DIV  = SEG_REFRESH_DIV,
  parameter int BLANK_CYCLES = SEG_BLANK_CYCLES
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic [4*DIGITS-1:0] value_i,
  input  logic                hex_mode_i,
  input  logic                lz_en_i,
  output logic [3:0]          num_o,
  output logic                is_hex_o,
  output logic [DIGITS-1:0]   digit_en_o,
  output logic                frame_done_o,
  output logic                pending_o
);
  localparam int CMAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = $clog2(DIGITS);
  slot_state_t         state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] act_val_q, act_val_d, sh_val_q;
  logic                act_hex_q, act_hex_d, act_lz_q, act_lz_d, sh_hex_q, sh_lz_q;
  logic                pending_q, pending_d;
  logic [3:0]          num_q, num_d;
  logic                is_hex_q, is_hex_d, fd_q, fd_d;
  logic [DIGITS-1:0]   en_q, en_d, mask;
  logic [7:0]          oh;
  logic                last_blank, last_show, commit, take_in, take_sh;
  always_comb begin
    last_blank = (state_q == BLANK) && (cnt_q == CW'(BLANK_CYCLES - 1));
    last_show  = (state_q == SHOW) && (cnt_q == CW'(REFRESH_DIV - 1));
    commit     = last_show && (idx_q == IW'(DIGITS - 1));
    take_in    = commit && load_i;
    take_sh    = commit && pending_q;
    state_d    = last_blank ? SHOW : last_show ? BLANK : state_q;
    cnt_d      = (last_blank || last_show) ? '0 : cnt_q + 1'b1;
    idx_d      = !last_show ? idx_q : (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    act_val_d  = take_in ? value_i    : take_sh ? sh_val_q : act_val_q;
    act_hex_d  = take_in ? hex_mode_i : take_sh ? sh_hex_q : act_hex_q;
    act_lz_d   = take_in ? lz_en_i    : take_sh ? sh_lz_q  : act_lz_q;
    pending_d  = commit ? 1'b0 : (pending_q | load_i);
  end
  seg_lz_mask #(.DIGITS(DIGITS)) u_lz (
    .value_i(act_val_d),
    .lz_i   (act_lz_d),
    .mask_o (mask)
  );
  // Outputs are derived from next-state values so the registered copies line up with the state they describe.
  always_comb begin
    oh       = onehot(3'(idx_d), DIGITS);
    num_d    = act_val_d[4*idx_d +: 4];
    is_hex_d = act_hex_d;
    en_d     = (state_d == SHOW) ? (oh[DIGITS-1:0] & ~mask) : '0;
    fd_d     = (state_d == SHOW) && (cnt_d == CW'(REFRESH_DIV - 1)) && (idx_d == IW'(DIGITS - 1));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BLANK;
      cnt_q     <= '0;
      idx_q     <= '0;
      act_val_q <= '0;
      act_hex_q <= 1'b0;
      act_lz_q  <= 1'b0;
      sh_val_q  <= '0;
      sh_hex_q  <= 1'b0;
      sh_lz_q   <= 1'b0;
      pending_q <= 1'b0;
      num_q     <= '0;
      is_hex_q  <= 1'b0;
      en_q      <= '0;
      fd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      act_val_q <= act_val_d;
      act_hex_q <= act_hex_d;
      act_lz_q  <= act_lz_d;
      pending_q <= pending_d;
      num_q     <= num_d;
      is_hex_q  <= is_hex_d;
      en_q      <= en_d;
      fd_q      <= fd_d;
      if (load_i) begin
        sh_val_q <= value_i;
        sh_hex_q <= hex_mode_i;
        sh_lz_q  <= lz_en_i;
      end
    end
  end
  assign num_o        = num_q;
  assign is_hex_o     = is_hex_q;
  assign digit_en_o   = en_q;
  assign frame_done_o = fd_q;
  assign pending_o    = pending_q;
endmodule

// File: tb/tb_seg_scanner.sv
// tb_seg_scanner: directed frame-level checks of seg_scanner with DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=2
module tb_seg_scanner;
  logic        clk = 1'b0, rst = 1'b1, load = 1'b0, hex_mode = 1'b0, lz_en = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  num, digit_en;
  logic        is_hex, frame_done, pending;
  int          n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  seg_scanner #(.DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load),
    .value_i     (value),
    .hex_mode_i  (hex_mode),
    .lz_en_i     (lz_en),
    .num_o       (num),
    .is_hex_o    (is_hex),
    .digit_en_o  (digit_en),
    .frame_done_o(frame_done),
    .pending_o   (pending)
  );
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  // Slot = 6 cycles (2 blank + 4 lit); frame_done on cycle 23; loads l1/l2 issued during that cycle.
  task automatic frame(input logic [15:0] shown, input logic hx, input logic [3:0] mask,
                       input int l1, input logic [15:0] v1, input int l2, input logic [15:0] v2,
                       input logic lh, input logic ll, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      int s, p;
      logic [3:0] e;
      logic pend;
      s    = c / 6;
      p    = c % 6;
      e    = (p < 2) ? 4'b0000 : ((4'b0001 << s) & ~mask);
      pend = (l1 >= 0 && l1 < 23 && c > l1) || (l2 >= 0 && l2 < 23 && c > l2);
      check($sformatf("en f%h c%0d", shown, c), 16'(digit_en), 16'(e));
      check($sformatf("num f%h c%0d", shown, c), 16'(num), 16'(shown[4*s +: 4]));
      check($sformatf("hex f%h c%0d", shown, c), 16'(is_hex), 16'(hx));
      check($sformatf("fd f%h c%0d", shown, c), 16'(frame_done), 16'(c == 23));
      check($sformatf("pend f%h c%0d", shown, c), 16'(pending), 16'(pend));
      load     = (c == l1) || (c == l2);
      value    = (c == l2) ? v2 : v1;
      hex_mode = lh;
      lz_en    = ll;
      @(posedge clk); #1;
    end
    load = 1'b0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst num", 16'(num), 16'h0);
    check("rst hex", 16'(is_hex), 16'h0);
    check("rst en", 16'(digit_en), 16'h0);
    check("rst fd", 16'(frame_done), 16'h0);
    check("rst pend", 16'(pending), 16'h0);
    frame(16'h0000, 1'b0, 4'b0000, 10, 16'h12AF, -1, 16'h0, 1'b1, 1'b0, 24);
    frame(16'h12AF, 1'b1, 4'b0000, 3, 16'h1111, 12, 16'h0042, 1'b0, 1'b0, 24);
    frame(16'h0042, 1'b0, 4'b0000, 5, 16'h0040, -1, 16'h0, 1'b0, 1'b1, 24);
    frame(16'h0040, 1'b0, 4'b1100, 7, 16'h0000, -1, 16'h0, 1'b0, 1'b1, 24);
    frame(16'h0000, 1'b0, 4'b1110, 23, 16'h9999, -1, 16'h0, 1'b0, 1'b0, 24);
    frame(16'h9999, 1'b0, 4'b0000, -1, 16'h0, -1, 16'h0, 1'b0, 1'b0, 24);
    frame(16'h9999, 1'b0, 4'b0000, -1, 16'h0, -1, 16'h0, 1'b0, 1'b0, 15);
    check("pre-rst en", 16'(digit_en), 16'h0004);
    rst   = 1'b1;
    load  = 1'b1;
    value = 16'h1234;
    @(posedge clk); #1;
    rst  = 1'b0;
    load = 1'b0;
    check("mid-rst num", 16'(num), 16'h0);
    check("mid-rst en", 16'(digit_en), 16'h0);
    check("mid-rst pend", 16'(pending), 16'h0);
    frame(16'h0000, 1'b0, 4'b0000, -1, 16'h0, -1, 16'h0, 1'b0, 1'b0, 24);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
